// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1 TAP controller with instruction register, bypass and IDCODE data registers,
// and control outputs for an external boundary-scan chain.
module jtag_tap_ctrl #(
    parameter int unsigned         IR_WIDTH   = 4,
    parameter logic [31:0]         IDCODE_VAL = 32'h0ABC_D0F1,
    parameter logic [IR_WIDTH-1:0] SAMPLE_OPC = 4'b0001,
    parameter logic [IR_WIDTH-1:0] IDCODE_OPC = 4'b0010
) (
    input  logic                tck,
    input  logic                trst,
    input  logic                tms,
    input  logic                tdi,
    input  logic                bsr_so,
    output logic                tdo,
    output logic                tdo_en,
    output logic                shift_dr,
    output logic                capture_en,
    output logic                update_en,
    output logic                mode,
    output logic                bsr_si,
    output logic [IR_WIDTH-1:0] instr
);

    localparam logic [IR_WIDTH-1:0] EXTEST_OPC  = '0;
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE  = {{(IR_WIDTH-2){1'b0}}, 2'b01};

    typedef enum logic [3:0] {
        TLR, RTI,
        SEL_DR, CAP_DR, SHF_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SHF_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
    } tap_state_e;

    typedef enum logic [1:0] {
        DR_BYPASS,
        DR_IDCODE,
        DR_BOUNDARY
    } dr_sel_e;

    tap_state_e          state_q, state_d;
    logic [IR_WIDTH-1:0] instr_q, instr_d;
    logic [IR_WIDTH-1:0] ir_sr_q;
    logic                bypass_q;
    logic [31:0]         idcode_q;
    logic                tdo_en_q, shift_dr_q, capture_en_q, update_en_q, mode_q;
    dr_sel_e             dr_sel, dr_sel_d;

    function automatic dr_sel_e dr_decode(input logic [IR_WIDTH-1:0] opc);
        if (opc == EXTEST_OPC || opc == SAMPLE_OPC) return DR_BOUNDARY;
        if (opc == IDCODE_OPC)                      return DR_IDCODE;
        return DR_BYPASS;
    endfunction

    // NOTE: every combinational output gets a default before the case so no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            TLR:    state_d = tms ? TLR    : RTI;
            RTI:    state_d = tms ? SEL_DR : RTI;
            SEL_DR: state_d = tms ? SEL_IR : CAP_DR;
            CAP_DR: state_d = tms ? EX1_DR : SHF_DR;
            SHF_DR: state_d = tms ? EX1_DR : SHF_DR;
            EX1_DR: state_d = tms ? UPD_DR : PAU_DR;
            PAU_DR: state_d = tms ? EX2_DR : PAU_DR;
            EX2_DR: state_d = tms ? UPD_DR : SHF_DR;
            UPD_DR: state_d = tms ? SEL_DR : RTI;
            SEL_IR: state_d = tms ? TLR    : CAP_IR;
            CAP_IR: state_d = tms ? EX1_IR : SHF_IR;
            SHF_IR: state_d = tms ? EX1_IR : SHF_IR;
            EX1_IR: state_d = tms ? UPD_IR : PAU_IR;
            PAU_IR: state_d = tms ? EX2_IR : PAU_IR;
            EX2_IR: state_d = tms ? UPD_IR : SHF_IR;
            UPD_IR: state_d = tms ? SEL_DR : RTI;
        endcase
    end

    // Entering TLR wins over an IR update so a reset path never latches a scanned opcode.
    always_comb begin
        instr_d = instr_q;
        if (state_q == UPD_IR) instr_d = ir_sr_q;
        if (state_d == TLR)    instr_d = IDCODE_OPC;
    end

    assign dr_sel   = dr_decode(instr_q);
    assign dr_sel_d = dr_decode(instr_d);

    // Control outputs are registered from next-state so they line up with the state they describe.
    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge tck or posedge trst) begin
        if (trst) begin
            state_q      <= TLR;
            instr_q      <= IDCODE_OPC;
            tdo_en_q     <= 1'b0;
            shift_dr_q   <= 1'b0;
            capture_en_q <= 1'b1;
            update_en_q  <= 1'b0;
            mode_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            instr_q      <= instr_d;
            tdo_en_q     <= (state_d == SHF_DR) || (state_d == SHF_IR);
            shift_dr_q   <= (state_d == SHF_DR);
            capture_en_q <= !(((state_d == CAP_DR) || (state_d == SHF_DR)) &&
                              (dr_sel_d == DR_BOUNDARY));
            update_en_q  <= (state_d == UPD_DR) && (dr_sel_d == DR_BOUNDARY);
            mode_q       <= (instr_d == EXTEST_OPC);
        end
    end

    // Shift registers act on the current state; they hold in every state not listed here.
    always_ff @(posedge tck or posedge trst) begin
        if (trst) begin
            ir_sr_q  <= '0;
            bypass_q <= 1'b0;
            idcode_q <= IDCODE_VAL;
        end else begin
            unique case (state_q)
                CAP_IR: ir_sr_q <= IR_CAPTURE;
                SHF_IR: ir_sr_q <= {tdi, ir_sr_q[IR_WIDTH-1:1]};
                CAP_DR: begin
                    if (dr_sel == DR_BYPASS) bypass_q <= 1'b0;
                    if (dr_sel == DR_IDCODE) idcode_q <= IDCODE_VAL;
                end
                SHF_DR: begin
                    if (dr_sel == DR_BYPASS) bypass_q <= tdi;
                    if (dr_sel == DR_IDCODE) idcode_q <= {tdi, idcode_q[31:1]};
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        tdo = 1'b0;
        if (state_q == SHF_IR) begin
            tdo = ir_sr_q[0];
        end else if (state_q == SHF_DR) begin
            unique case (dr_sel)
                DR_BYPASS:   tdo = bypass_q;
                DR_IDCODE:   tdo = idcode_q[0];
                DR_BOUNDARY: tdo = bsr_so;
                default:     tdo = 1'b0;
            endcase
        end
    end

    assign tdo_en     = tdo_en_q;
    assign shift_dr   = shift_dr_q;
    assign capture_en = capture_en_q;
    assign update_en  = update_en_q;
    assign mode       = mode_q;
    assign bsr_si     = tdi;
    assign instr      = instr_q;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Directed bench for jtag_tap_ctrl: a table of tms/tdi/bsr_so steps with expected outputs,
// followed by hand-written sequences for IDCODE readout, EXTEST load, resets and the 5x tms=1 rule.
module tb_jtag_tap_ctrl;

    logic       tck = 1'b0;
    logic       trst, tms, tdi, bsr_so;
    logic       tdo, tdo_en, shift_dr, capture_en, update_en, mode, bsr_si;
    logic [3:0] instr;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic       tms, tdi, bso;
        logic       tdo, en, sd, ce, ue, mode;
        logic [3:0] instr;
    } vec_t;

    vec_t tbl[$];

    jtag_tap_ctrl dut (
        .tck        (tck),
        .trst       (trst),
        .tms        (tms),
        .tdi        (tdi),
        .bsr_so     (bsr_so),
        .tdo        (tdo),
        .tdo_en     (tdo_en),
        .shift_dr   (shift_dr),
        .capture_en (capture_en),
        .update_en  (update_en),
        .mode       (mode),
        .bsr_si     (bsr_si),
        .instr      (instr)
    );

    always #5 tck = ~tck;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic t, input logic d, input logic b,
                       input logic o, input logic en, input logic sd, input logic ce,
                       input logic ue, input logic m, input logic [3:0] ins);
        vec_t v;
        v.tms = t; v.tdi = d; v.bso = b;
        v.tdo = o; v.en = en; v.sd = sd; v.ce = ce; v.ue = ue; v.mode = m; v.instr = ins;
        tbl.push_back(v);
    endtask

    // Drive on the falling edge, let the rising edge act, then sample 1 ns later.
    task automatic step(input logic t, input logic d = 1'b0, input logic b = 1'b0);
        @(negedge tck);
        tms = t; tdi = d; bsr_so = b;
        @(posedge tck);
        #1;
    endtask

    task automatic pulse_reset;
        @(negedge tck);
        trst = 1'b1;
        #2;
        trst = 1'b0;
    endtask

    task automatic check_idle(input string name);
        check(name, {tdo, tdo_en, shift_dr, capture_en, update_en, mode, instr},
              {6'b000100, 4'b0010});
    endtask

    logic [31:0] rx;

    initial begin
        trst = 1'b1; tms = 1'b1; tdi = 1'b0; bsr_so = 1'b0;

        // {tms,tdi,bso} -> {tdo,en,sd,ce,ue,mode,instr} after the edge
        // IR scan of 1111 (BYPASS)
        add(0,0,0, 0,0,0,1,0,0, 4'h2);  // RTI
        add(1,0,0, 0,0,0,1,0,0, 4'h2);  // SEL_DR
        add(1,0,0, 0,0,0,1,0,0, 4'h2);  // SEL_IR
        add(0,0,0, 0,0,0,1,0,0, 4'h2);  // CAP_IR
        add(0,0,0, 1,1,0,1,0,0, 4'h2);  // SHF_IR, ir=0001
        add(0,1,0, 0,1,0,1,0,0, 4'h2);
        add(0,1,0, 0,1,0,1,0,0, 4'h2);
        add(0,1,0, 0,1,0,1,0,0, 4'h2);
        add(1,1,0, 0,0,0,1,0,0, 4'h2);  // EX1_IR
        add(1,0,0, 0,0,0,1,0,0, 4'h2);  // UPD_IR, instr holds
        add(0,0,0, 0,0,0,1,0,0, 4'hF);  // RTI, instr=1111
        // bypass DR scan of 1,0,1,1
        add(1,0,0, 0,0,0,1,0,0, 4'hF);  // SEL_DR
        add(0,0,0, 0,0,0,1,0,0, 4'hF);  // CAP_DR
        add(0,0,0, 0,1,1,1,0,0, 4'hF);  // SHF_DR, bypass=0
        add(0,1,0, 1,1,1,1,0,0, 4'hF);
        add(0,0,0, 0,1,1,1,0,0, 4'hF);
        add(0,1,0, 1,1,1,1,0,0, 4'hF);
        add(1,1,0, 0,0,0,1,0,0, 4'hF);  // EX1_DR
        add(1,0,0, 0,0,0,1,0,0, 4'hF);  // UPD_DR, no boundary update
        add(0,0,0, 0,0,0,1,0,0, 4'hF);  // RTI
        // IR scan of 0001 (SAMPLE)
        add(1,0,0, 0,0,0,1,0,0, 4'hF);
        add(1,0,0, 0,0,0,1,0,0, 4'hF);
        add(0,0,0, 0,0,0,1,0,0, 4'hF);
        add(0,0,0, 1,1,0,1,0,0, 4'hF);  // SHF_IR
        add(0,1,0, 0,1,0,1,0,0, 4'hF);
        add(0,0,0, 0,1,0,1,0,0, 4'hF);
        add(0,0,0, 0,1,0,1,0,0, 4'hF);
        add(1,0,0, 0,0,0,1,0,0, 4'hF);  // EX1_IR
        add(1,0,0, 0,0,0,1,0,0, 4'hF);  // UPD_IR
        add(0,0,0, 0,0,0,1,0,0, 4'h1);  // RTI, instr=SAMPLE
        // boundary DR scan with a pause
        add(1,0,0, 0,0,0,1,0,0, 4'h1);  // SEL_DR
        add(0,0,0, 0,0,0,0,0,0, 4'h1);  // CAP_DR, capture_en low
        add(0,0,1, 1,1,1,0,0,0, 4'h1);  // SHF_DR, tdo=bsr_so
        add(0,0,0, 0,1,1,0,0,0, 4'h1);
        add(1,0,1, 0,0,0,1,0,0, 4'h1);  // EX1_DR, bsr_so ignored
        add(0,0,1, 0,0,0,1,0,0, 4'h1);  // PAU_DR
        add(1,0,0, 0,0,0,1,0,0, 4'h1);  // EX2_DR
        add(0,0,1, 1,1,1,0,0,0, 4'h1);  // SHF_DR again
        add(1,0,0, 0,0,0,1,0,0, 4'h1);  // EX1_DR
        add(1,0,0, 0,0,0,1,1,0, 4'h1);  // UPD_DR, update pulse
        add(0,0,0, 0,0,0,1,0,0, 4'h1);  // RTI, pulse gone
        add(1,0,0, 0,0,0,1,0,0, 4'h1);  // SEL_DR
        add(1,0,0, 0,0,0,1,0,0, 4'h1);  // SEL_IR
        add(1,0,0, 0,0,0,1,0,0, 4'h2);  // TLR, instr=IDCODE
        add(1,0,0, 0,0,0,1,0,0, 4'h2);  // TLR
        add(0,0,0, 0,0,0,1,0,0, 4'h2);  // RTI

        #2;
        check_idle("reset_async");
        repeat (2) @(posedge tck);
        #1;
        check_idle("reset_held");
        @(negedge tck);
        trst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].tms, tbl[i].tdi, tbl[i].bso);
            check($sformatf("vec[%0d]", i),
                  {tdo, tdo_en, shift_dr, capture_en, update_en, mode, bsr_si, instr},
                  {tbl[i].tdo, tbl[i].en, tbl[i].sd, tbl[i].ce, tbl[i].ue, tbl[i].mode,
                   tbl[i].tdi, tbl[i].instr});
        end

        // IDCODE readout after reset, LSB first
        pulse_reset();
        step(0); step(1); step(0); step(0);
        for (int i = 0; i < 32; i++) begin
            rx[i] = tdo;
            step(i == 31, 1'b0);
        end
        check("idcode_read", rx, 32'h0ABC_D0F1);
        step(1); step(0);

        // IR scan of 0000 (EXTEST)
        step(1); step(1); step(0); step(0);
        rx = '0;
        for (int i = 0; i < 4; i++) begin
            rx[i] = tdo;
            step(i == 3, 1'b0);
        end
        check("ir_capture_out", rx[3:0], 4'b0001);
        step(1);
        check("instr_hold_upd_ir", instr, 4'b0010);
        step(0);
        check("extest_instr_mode", {instr, mode}, {4'b0000, 1'b1});

        // trst while in SHF_DR under EXTEST
        step(1); step(0); step(0);
        check("extest_shf_dr", {shift_dr, capture_en, tdo_en, mode}, 4'b1011);
        #2;
        trst = 1'b1;
        #1;
        check_idle("reset_mid_shf_dr");
        @(negedge tck);
        trst = 1'b0;

        // trst during a partial IR scan must not load the partial opcode
        step(0); step(1); step(1); step(0); step(0);
        step(0, 1'b1); step(0, 1'b1);
        check("partial_ir_tdo_en", tdo_en, 1'b1);
        pulse_reset();
        #1;
        check_idle("reset_mid_shf_ir");
        step(0);
        check("instr_after_abort", instr, 4'b0010);

        // five tms=1 from SHF_IR returns to TLR, passing through UPD_IR on the way
        step(1); step(1); step(0); step(0);
        for (int i = 0; i < 4; i++) step(0, 1'b1);
        step(1, 1'b1); step(1, 1'b1); step(1, 1'b1); step(1, 1'b1);
        check("instr_before_tlr", instr, 4'hF);
        step(1, 1'b1);
        check("instr_at_tlr", instr, 4'h2);
        step(0);
        step(1); step(0); step(0);
        check("rti_then_idcode_shift", {tdo_en, shift_dr, tdo}, 3'b111);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
